// File: rtl/sc_io_bridge.sv
// sc_io_bridge: memory-mapped I/O window for the single-cycle computer.
// Provides NUM_OUT read-back output ports, NUM_IN synchronised input ports,
// a sticky write-1-to-clear change-detect STATUS register and a wrap timer.
// Optional build macro IO_DEBOUNCE_EN adds a per-port debounce counter
// behind the synchroniser; without it only the 2-flop synchroniser exists.
module sc_io_bridge #(
  parameter int          NUM_OUT         = 2,
  parameter int          NUM_IN          = 2,
  parameter int          DATA_W          = 32,
  parameter logic [31:0] IO_BASE         = 32'h0000_FF00,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [31:0]                addr,
  input  logic [31:0]                datain,
  input  logic                       we,
  output logic                       io_sel,
  output logic [31:0]                dataout,
  input  logic [NUM_IN*DATA_W-1:0]   in_port,
  output logic [NUM_OUT*DATA_W-1:0]  out_port
);
  localparam int         OW         = NUM_OUT * DATA_W;
  localparam int         IW         = NUM_IN * DATA_W;
  localparam logic [7:0] OFF_STATUS = 8'h80;
  localparam logic [7:0] OFF_TCOUNT = 8'h84;
  localparam logic [7:0] OFF_TCMP   = 8'h88;
  localparam logic [7:0] OFF_TCTRL  = 8'h8C;
  localparam logic [5:0] NOUT6      = 6'(NUM_OUT);
  localparam logic [5:0] NIN6       = 6'(NUM_IN);

  logic [5:0]        word_s;
  logic [7:0]        off_s;
  logic              wr_s;
  logic              unused_addr_s;
  logic [OW-1:0]     out_q, out_d;
  logic [IW-1:0]     sync1_q, sync1_d, sync2_q, sync2_d, in_s;
  logic [NUM_IN-1:0] status_q, status_d, set_s, clr_s;
  logic [31:0]       tcount_q, tcount_d, tcmp_q, tcmp_d;
  logic              en_q, en_d, wrap_q, wrap_d, wrap_set_s, wrap_clr_s;

  // Byte lanes are ignored: every register is word wide.
  assign io_sel        = (addr[31:8] == IO_BASE[31:8]);
  assign word_s        = addr[7:2];
  assign off_s         = {addr[7:2], 2'b00};
  assign wr_s          = we && io_sel;
  assign unused_addr_s = &{1'b0, addr[1:0]};
  assign out_port      = out_q;

`ifdef IO_DEBOUNCE_EN
  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  logic [IW-1:0]       in_q, in_d;
  logic [NUM_IN*CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_nx_s;

  assign in_s = in_q;

  // Debounce: accept the synchronised value after DEBOUNCE_CYCLES consecutive differing edges.
  always_comb begin
    in_d     = in_q;
    cnt_d    = cnt_q;
    set_s    = {NUM_IN{1'b0}};
    cnt_nx_s = {CNT_W{1'b0}};
    for (int k = 0; k < NUM_IN; k++) begin
      if (sync2_q[k*DATA_W +: DATA_W] != in_q[k*DATA_W +: DATA_W]) begin
        cnt_nx_s = cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
        if (cnt_nx_s == CNT_MAX) begin
          in_d[k*DATA_W +: DATA_W] = sync2_q[k*DATA_W +: DATA_W];
          cnt_d[k*CNT_W +: CNT_W]  = {CNT_W{1'b0}};
          set_s[k]                 = 1'b1;
        end else begin
          cnt_d[k*CNT_W +: CNT_W]  = cnt_nx_s;
        end
      end else begin
        cnt_d[k*CNT_W +: CNT_W] = {CNT_W{1'b0}};
      end
    end
  end

  // Debounced input value and per-port counters.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      in_q  <= {IW{1'b0}};
      cnt_q <= {(NUM_IN*CNT_W){1'b0}};
    end else begin
      in_q  <= in_d;
      cnt_q <= cnt_d;
    end
  end
`else
  assign in_s = sync2_q;

  // Change detect: flag a port when the second synchroniser stage loads a new value.
  always_comb begin
    set_s = {NUM_IN{1'b0}};
    for (int k = 0; k < NUM_IN; k++) begin
      if (sync1_q[k*DATA_W +: DATA_W] != sync2_q[k*DATA_W +: DATA_W]) begin
        set_s[k] = 1'b1;
      end else begin
        set_s[k] = 1'b0;
      end
    end
  end
`endif

  // Next-state for ports, status, and timer; a CPU write to TCOUNT beats the count.
  always_comb begin
    out_d      = out_q;
    sync1_d    = in_port;
    sync2_d    = sync1_q;
    tcount_d   = tcount_q;
    tcmp_d     = tcmp_q;
    en_d       = en_q;
    wrap_set_s = 1'b0;
    wrap_clr_s = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (wr_s && (word_s == 6'(k))) begin
        out_d[k*DATA_W +: DATA_W] = datain[DATA_W-1:0];
      end else begin
        out_d[k*DATA_W +: DATA_W] = out_q[k*DATA_W +: DATA_W];
      end
    end
    if (wr_s && (off_s == OFF_STATUS)) begin
      clr_s = datain[NUM_IN-1:0];
    end else begin
      clr_s = {NUM_IN{1'b0}};
    end
    status_d = (status_q & ~clr_s) | set_s;
    if (wr_s && (off_s == OFF_TCOUNT)) begin
      tcount_d = datain;
    end else if (en_q && (tcount_q == tcmp_q)) begin
      tcount_d   = 32'd0;
      wrap_set_s = 1'b1;
    end else if (en_q) begin
      tcount_d = tcount_q + 32'd1;
    end else begin
      tcount_d = tcount_q;
    end
    if (wr_s && (off_s == OFF_TCMP)) begin
      tcmp_d = datain;
    end else begin
      tcmp_d = tcmp_q;
    end
    if (wr_s && (off_s == OFF_TCTRL)) begin
      en_d       = datain[0];
      wrap_clr_s = datain[1];
    end else begin
      en_d       = en_q;
      wrap_clr_s = 1'b0;
    end
    wrap_d = wrap_set_s | (wrap_q & ~wrap_clr_s);
  end

  // Combinational read mux; anything unmapped or outside the window reads zero.
  always_comb begin
    dataout = 32'd0;
    if (io_sel) begin
      if (word_s < 6'd16) begin
        if (word_s < NOUT6) begin
          dataout[DATA_W-1:0] = out_q[int'(word_s)*DATA_W +: DATA_W];
        end else begin
          dataout = 32'd0;
        end
      end else if (word_s < 6'd32) begin
        if ((word_s - 6'd16) < NIN6) begin
          dataout[DATA_W-1:0] = in_s[int'(word_s - 6'd16)*DATA_W +: DATA_W];
        end else begin
          dataout = 32'd0;
        end
      end else begin
        case (off_s)
          OFF_STATUS: dataout[NUM_IN-1:0] = status_q;
          OFF_TCOUNT: dataout = tcount_q;
          OFF_TCMP:   dataout = tcmp_q;
          OFF_TCTRL:  dataout = {30'd0, wrap_q, en_q};
          default:    dataout = 32'd0;
        endcase
      end
    end else begin
      dataout = 32'd0;
    end
  end

  // Architectural state registers with asynchronous clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_q    <= {OW{1'b0}};
      sync1_q  <= {IW{1'b0}};
      sync2_q  <= {IW{1'b0}};
      status_q <= {NUM_IN{1'b0}};
      tcount_q <= 32'd0;
      tcmp_q   <= 32'd0;
      en_q     <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      out_q    <= out_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      status_q <= status_d;
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      en_q     <= en_d;
      wrap_q   <= wrap_d;
    end
  end
endmodule

// File: tb/tb_sc_io_bridge.sv
// Self-checking bench for sc_io_bridge: directed register-map scenarios followed
// by random bus traffic, all compared against a behavioural model of the I/O map.
module tb_sc_io_bridge;
  localparam int          NUM_OUT = 2;
  localparam int          NUM_IN  = 2;
  localparam int          DATA_W  = 32;
  localparam logic [31:0] BASE    = 32'h0000_FF00;
`ifdef IO_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int LAT = 2 + DB;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] addr, datain, dataout;
  logic        we, io_sel;
  logic [NUM_IN*DATA_W-1:0]  in_port;
  logic [NUM_OUT*DATA_W-1:0] out_port;

  sc_io_bridge #(
    .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN), .DATA_W(DATA_W), .IO_BASE(BASE),
    .DEBOUNCE_CYCLES((DB == 0) ? 16 : DB)
  ) dut (
    .clock(clock), .resetn(resetn), .addr(addr), .datain(datain), .we(we),
    .io_sel(io_sel), .dataout(dataout), .in_port(in_port), .out_port(out_port)
  );

  always #5 clock = ~clock;

  // Behavioural model of the visible register map.
  logic [31:0]       out_m [NUM_OUT];
  logic [DATA_W-1:0] in_m  [NUM_IN];
  logic [NUM_IN-1:0] status_m;
  logic [31:0]       tc_m, tcmp_m;
  bit                en_m, wrap_m;
  logic [NUM_IN*DATA_W-1:0] hist [$];   // in_port as sampled at each clock edge
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_OUT; k++) out_m[k] = 32'd0;
    for (int k = 0; k < NUM_IN; k++) in_m[k] = '0;
    status_m = '0; tc_m = 32'd0; tcmp_m = 32'd0; en_m = 1'b0; wrap_m = 1'b0;
    hist.delete();
    for (int i = 0; i < DB + 3; i++) hist.push_back('0);
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd256);
  endfunction

  function automatic logic [31:0] read_m(input logic [31:0] a);
    int w;
    w = int'(a[7:2]);
    if (!in_window(a)) return 32'd0;
    if (w < 16) return (w < NUM_OUT) ? out_m[w] : 32'd0;
    if (w < 32) return ((w - 16) < NUM_IN) ? 32'(in_m[w - 16]) : 32'd0;
    case (w)
      32: return 32'(status_m);
      33: return tc_m;
      34: return tcmp_m;
      35: return {30'd0, wrap_m, en_m};
      default: return 32'd0;
    endcase
  endfunction

  // Apply the bus/input values present at a rising edge to the model.
  task automatic model_edge();
    bit wr, wrap_set, accept;
    logic [7:0] off;
    logic [NUM_IN-1:0] set, clr;
    logic [NUM_IN*DATA_W-1:0] smp;
    logic [DATA_W-1:0] s;
    wr  = we && in_window(addr);
    off = {addr[7:2], 2'b00};
    hist.push_back(in_port);
    if (hist.size() > 64) void'(hist.pop_front());
    set = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      smp = hist[hist.size() - 2];
      s = smp[k*DATA_W +: DATA_W];
      accept = (s != in_m[k]);
      for (int j = 2; j <= DB + 1; j++) begin
        smp = hist[hist.size() - j];
        if (smp[k*DATA_W +: DATA_W] == in_m[k]) accept = 1'b0;
      end
      if (accept) begin
        in_m[k] = s;
        set[k] = 1'b1;
      end
    end
    clr = (wr && off == 8'h80) ? datain[NUM_IN-1:0] : '0;
    status_m = (status_m & ~clr) | set;
    wrap_set = 1'b0;
    if (wr && off == 8'h84) tc_m = datain;
    else if (en_m) begin
      if (tc_m == tcmp_m) begin tc_m = 32'd0; wrap_set = 1'b1; end
      else tc_m = tc_m + 32'd1;
    end
    if (wr && off == 8'h8C) begin
      wrap_m = wrap_set | (wrap_m & !datain[1]);
      en_m   = datain[0];
    end else begin
      wrap_m = wrap_m | wrap_set;
    end
    if (wr && off == 8'h88) tcmp_m = datain;
    if (wr && off < 8'h40 && int'(off[7:2]) < NUM_OUT) out_m[int'(off[7:2])] = datain;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
    addr = a; datain = d; we = w;
  endtask

  // Check the current read and outputs, then advance one clock edge.
  task automatic step();
    #1;
    check("io_sel", io_sel, in_window(addr));
    check("dataout", dataout, read_m(addr));
    check("out_port", out_port, {out_m[1], out_m[0]});
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic peek(input logic [31:0] a, input string tag, input logic [31:0] exp);
    logic [31:0] sa;
    logic sw;
    sa = addr; sw = we;
    addr = a; we = 1'b0;
    #1;
    check(tag, dataout, exp);
    addr = sa; we = sw;
  endtask

  task automatic rand_run(input int n);
    int w;
    logic [31:0] a, d;
    for (int i = 0; i < n; i++) begin
      w = $urandom_range(0, 36);
      a = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      d = $urandom;
      if (w == 33 || w == 34) d = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) in_port = {$urandom, $urandom};
      drive(a, d, 1'($urandom_range(0, 1)));
      step();
    end
  endtask

  logic [31:0] tseq [6];

  initial begin
    tseq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    // Reset with inputs driven high.
    resetn = 1'b0; in_port = '1; drive(BASE + 32'h80, 32'd0, 1'b0);
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_port", out_port, 64'd0);
    check("rst_io_sel", io_sel, 1'b1);
    peek(BASE + 32'h80, "rst_status", 32'd0);
    peek(BASE + 32'h84, "rst_tcount", 32'd0);
    in_port = '0;
    resetn = 1'b1;

    // Output port write, read-back, and unmapped port.
    drive(BASE + 32'h04, 32'hDEAD_BEEF, 1'b1); step();
    drive(BASE + 32'h04, 32'd0, 1'b0);
    #1 check("out1_value", out_port[63:32], 32'hDEAD_BEEF);
    peek(BASE + 32'h04, "out1_readback", 32'hDEAD_BEEF);
    drive(BASE + 32'h3C, 32'h1234_5678, 1'b1); step();
    drive(BASE + 32'h3C, 32'd0, 1'b0);
    peek(BASE + 32'h3C, "out15_read", 32'd0);
    check("out_untouched", out_port, {32'hDEAD_BEEF, 32'd0});

    // Input synchronisation latency and sticky status.
    drive(BASE + 32'h40, 32'd0, 1'b0);
    in_port[31:0] = 32'h5A;
    repeat (LAT - 1) step();
    peek(BASE + 32'h40, "in0_early", 32'd0);
    peek(BASE + 32'h80, "status_early", 32'd0);
    step();
    peek(BASE + 32'h40, "in0_latency", 32'h5A);
    peek(BASE + 32'h80, "status_set", 32'h1);
    drive(BASE + 32'h80, 32'h1, 1'b1); step();
    drive(BASE + 32'h80, 32'd0, 1'b0);
    peek(BASE + 32'h80, "status_w1c", 32'd0);
    in_port[31:0] = 32'hA5;
    repeat (LAT - 1) step();
    drive(BASE + 32'h80, 32'h1, 1'b1); step();
    drive(BASE + 32'h80, 32'd0, 1'b0);
    peek(BASE + 32'h80, "status_set_wins", 32'h1);

    // Timer wrap sequence, TCOUNT override, disable.
    drive(BASE + 32'h88, 32'd3, 1'b1); step();
    drive(BASE + 32'h8C, 32'd1, 1'b1); step();
    drive(BASE + 32'h84, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      peek(BASE + 32'h84, "tcount_seq", tseq[i]);
      step();
    end
    peek(BASE + 32'h84, "tcount_seq", tseq[5]);
    peek(BASE + 32'h8C, "wrap_after_wrap", 32'h3);
    drive(BASE + 32'h84, 32'd2, 1'b1); step();
    drive(BASE + 32'h84, 32'd0, 1'b0);
    peek(BASE + 32'h84, "tcount_written", 32'd2);
    step();
    peek(BASE + 32'h84, "tcount_next", 32'd3);
    drive(BASE + 32'h8C, 32'h2, 1'b1); step();
    drive(BASE + 32'h84, 32'd0, 1'b0);
    peek(BASE + 32'h8C, "wrap_set_wins", 32'h2);
    repeat (3) step();
    peek(BASE + 32'h84, "tcount_hold", 32'd0);
    drive(BASE + 32'h8C, 32'h2, 1'b1); step();
    peek(BASE + 32'h8C, "wrap_cleared", 32'd0);

    // Accesses outside the window.
    drive(BASE + 32'h100, 32'hFFFF_FFFF, 1'b1);
    #1 check("outside_io_sel", io_sel, 1'b0);
    check("outside_dataout", dataout, 32'd0);
    step();
    drive(BASE + 32'h184, 32'h55, 1'b1); step();
    drive(BASE, 32'd0, 1'b0);
    peek(BASE + 32'h84, "outside_tcount", 32'd0);
    check("outside_out_port", out_port, {32'hDEAD_BEEF, 32'd0});

`ifdef IO_DEBOUNCE_EN
    // Short glitch is rejected, sustained change is accepted.
    drive(BASE + 32'h80, 32'h3, 1'b1); step();
    drive(BASE + 32'h44, 32'd0, 1'b0);
    in_port[63:32] = 32'h77;
    repeat (3) step();
    in_port[63:32] = 32'h0;
    repeat (8) step();
    peek(BASE + 32'h44, "glitch_in1", 32'd0);
    peek(BASE + 32'h80, "glitch_status", 32'd0);
    in_port[63:32] = 32'h77;
    repeat (LAT - 1) step();
    peek(BASE + 32'h44, "db_in1_early", 32'd0);
    step();
    peek(BASE + 32'h44, "db_in1", 32'h77);
    peek(BASE + 32'h80, "db_status", 32'h2);
`endif

    // Random traffic against the model.
    rand_run(400);

    // Asynchronous reset in the middle of operation.
    drive(BASE + 32'h84, 32'd0, 1'b0);
    #2 resetn = 1'b0;
    #1 check("arst_out_port", out_port, 64'd0);
    check("arst_tcount", dataout, 32'd0);
    model_reset();
    peek(BASE + 32'h80, "arst_status", 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    rand_run(150);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
